instr_mem: RTL and testbench

// - Instruction memory answering the fetch stage: takes the fetch-stage pc, returns the 32-bit word fed to its instruction_in.
// - Includes a byte-serial program loader (valid/ready) that fills memory before/between runs.
// - Out-of-range and during-load fetches return NOP, so the fetch stage keeps advancing harmlessly.

---
 rtl/instr_mem.sv | 109 ++++++++++
 tb/tb_instr_mem.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem.sv
// instr_mem: fetch-side instruction memory with a byte-serial, big-endian program loader.
// Define IMEM_MISALIGN_TRAP_EN to add a misalign output and NOP out unaligned fetches.
module instr_mem #(
  parameter int          ADDR_W   = 8,
  parameter logic [31:0] NOP_WORD = 32'hC800_0000
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       pc,
  output logic [31:0]       instruction,
  input  logic              load_start,
  input  logic              load_end,
  input  logic              load_valid,
  input  logic [7:0]        load_byte,
  output logic              load_ready,
  output logic              load_busy,
  output logic [ADDR_W:0]   load_count,
  output logic              load_ovf
`ifdef IMEM_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic {IDLE, FILL} state_t;

  state_t            state;
  logic [31:0]       mem [DEPTH];
  logic [1:0]        byte_cnt;
  logic [23:0]       asm_q;
  logic              full;
  logic              accept;
  logic              commit;
  logic              in_range;
  logic [ADDR_W-1:0] idx;

  assign full       = (load_count == FULL_CNT);
  assign load_busy  = (state == FILL);
  assign load_ready = load_busy && !full;
  assign in_range   = (pc[31:ADDR_W+2] == '0);
  assign idx        = pc[ADDR_W+1:2];

  // A load_start in the same cycle discards any offered byte: the restart wins.
  assign accept = load_busy && load_valid && load_ready && !load_start;
  assign commit = accept && (byte_cnt == 2'd3);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      load_count <= '0;
      load_ovf   <= 1'b0;
      byte_cnt   <= 2'd0;
      asm_q      <= '0;
    end else if (load_start) begin
      state      <= FILL;
      load_count <= '0;
      load_ovf   <= 1'b0;
      byte_cnt   <= 2'd0;
    end else if (state == FILL) begin
      if (load_end)
        state <= IDLE;
      if (accept) begin
        asm_q    <= {asm_q[15:0], load_byte};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3)
          load_count <= load_count + 1'b1;
      end
      if (load_valid && full)
        load_ovf <= 1'b1;
    end
  end

  // Storage is never reset so a program survives a reset of the core.
  always_ff @(posedge clk) begin
    if (rst_n && commit)
      mem[load_count[ADDR_W-1:0]] <= {asm_q, load_byte};
  end

`ifdef IMEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      instruction <= NOP_WORD;
      misalign    <= 1'b0;
    end else begin
      misalign <= |pc[1:0];
      if (state == FILL || !in_range || (pc[1:0] != 2'b00))
        instruction <= NOP_WORD;
      else
        instruction <= mem[idx];
    end
  end
`else
  logic pc_lo_unused;
  assign pc_lo_unused = ^pc[1:0];

  always_ff @(posedge clk) begin
    if (!rst_n)
      instruction <= NOP_WORD;
    else if (state == FILL || !in_range)
      instruction <= NOP_WORD;
    else
      instruction <= mem[idx];
  end
`endif

endmodule

// File: tb/tb_instr_mem.sv
// Bench for instr_mem: directed loads plus randomized loads/fetches against an array model.
module tb_instr_mem;
  localparam logic [31:0] NOP = 32'hC800_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, load_start, load_end, load_valid, load_ready, load_busy, load_ovf;
  logic [31:0] pc, instruction;
  logic [7:0]  load_byte;
  logic [8:0]  load_count;

  logic        s_start, s_end, s_valid, s_ready, s_busy, s_ovf;
  logic [31:0] s_pc, s_instr;
  logic [7:0]  s_byte;
  logic [2:0]  s_count;
`ifdef IMEM_MISALIGN_TRAP_EN
  logic        misalign, s_misalign;
`endif

  instr_mem #(.ADDR_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instruction(instruction),
    .load_start(load_start), .load_end(load_end), .load_valid(load_valid),
    .load_byte(load_byte), .load_ready(load_ready), .load_busy(load_busy),
    .load_count(load_count), .load_ovf(load_ovf)
`ifdef IMEM_MISALIGN_TRAP_EN
    , .misalign(misalign)
`endif
  );

  instr_mem #(.ADDR_W(2)) dut_small (
    .clk(clk), .rst_n(rst_n), .pc(s_pc), .instruction(s_instr),
    .load_start(s_start), .load_end(s_end), .load_valid(s_valid),
    .load_byte(s_byte), .load_ready(s_ready), .load_busy(s_busy),
    .load_count(s_count), .load_ovf(s_ovf)
`ifdef IMEM_MISALIGN_TRAP_EN
    , .misalign(s_misalign)
`endif
  );

  int          total = 0;
  int          bad   = 0;
  logic [31:0] ref_mem [256];
  logic [7:0]  stream [$];
  int          last_n;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] exp_fetch(input logic [31:0] a);
    if (a[31:10] != 22'd0) return NOP;
`ifdef IMEM_MISALIGN_TRAP_EN
    if (a[1:0] != 2'b00) return NOP;
`endif
    return ref_mem[a[9:2]];
  endfunction

  task automatic fetch_chk(input string tag, input logic [31:0] a);
    pc = a;
    tick();
    check(tag, instruction, exp_fetch(a));
`ifdef IMEM_MISALIGN_TRAP_EN
    check({tag, "_mis"}, {31'b0, misalign}, {31'b0, |a[1:0]});
`endif
  endtask

  // Plays the queued bytes with random idle gaps, then updates the model:
  // only whole words are committed, in big-endian byte order.
  task automatic do_load();
    int n;
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
    check("busy_on", {31'b0, load_busy}, 32'd1);
    check("ready_on", {31'b0, load_ready}, 32'd1);
    foreach (stream[i]) begin
      repeat ($urandom_range(0, 2)) begin
        tick();
        check("fill_nop_idle", instruction, NOP);
      end
      load_valid = 1'b1;
      load_byte  = stream[i];
      tick();
      load_valid = 1'b0;
      check("fill_nop", instruction, NOP);
    end
    load_end = 1'b1;
    tick();
    load_end = 1'b0;
    n = stream.size() / 4;
    for (int w = 0; w < n; w++)
      ref_mem[w] = {stream[4*w], stream[4*w+1], stream[4*w+2], stream[4*w+3]};
    check("load_count", {23'b0, load_count}, n);
    check("busy_off", {31'b0, load_busy}, 32'd0);
    if (n > 0) last_n = n;
  endtask

  initial begin
    rst_n = 1'b0; pc = 32'd0; load_start = 1'b0; load_end = 1'b0;
    load_valid = 1'b0; load_byte = 8'd0;
    s_start = 1'b0; s_end = 1'b0; s_valid = 1'b0; s_byte = 8'd0; s_pc = 32'd0;
    last_n = 0;

    tick();
    check("rst_instr", instruction, NOP);
    tick();
    check("rst_instr_held", instruction, NOP);
    check("rst_busy", {31'b0, load_busy}, 32'd0);
    check("rst_ready", {31'b0, load_ready}, 32'd0);
    check("rst_count", {23'b0, load_count}, 32'd0);
    check("rst_ovf", {31'b0, load_ovf}, 32'd0);
    rst_n = 1'b1;

    pc = 32'd4;
    stream = '{8'hC0, 8'h00, 8'h00, 8'h05, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    do_load();
    pc = 32'd0; tick();
    check("dir_word0", instruction, 32'hC000_0005);
    pc = 32'd4; tick();
    check("dir_word1", instruction, 32'hFFFF_FFFF);

    stream = '{8'h11, 8'h22, 8'h33};
    do_load();
    pc = 32'd0; tick();
    check("partial_kept", instruction, 32'hC000_0005);

    for (int r = 0; r < 3; r++) begin
      int words;
      words = $urandom_range(3, 12);
      stream = {};
      for (int b = 0; b < words * 4 + $urandom_range(0, 3); b++)
        stream.push_back(8'($urandom));
      pc = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      do_load();
      for (int k = 0; k < 16; k++) begin
        logic [31:0] a;
        a = {22'd0, 8'($urandom_range(0, last_n - 1)), 2'($urandom)};
        if ($urandom_range(0, 5) == 0) a[31:10] = 22'($urandom) | 22'd1;
        fetch_chk("rand_fetch", a);
      end
    end

    fetch_chk("pc9", 32'd9);
`ifndef IMEM_MISALIGN_TRAP_EN
    check("pc9_word2", instruction, ref_mem[2]);
`else
    check("pc9_nop", instruction, NOP);
`endif

    // Restart: two words committed, then start+end together keeps FILL and clears the count.
    stream = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, 8'h0A};
    load_start = 1'b1; tick(); load_start = 1'b0;
    foreach (stream[i]) begin
      load_valid = 1'b1; load_byte = stream[i]; tick();
    end
    load_valid = 1'b0;
    ref_mem[0] = 32'h0102_0304;
    ref_mem[1] = 32'h0506_0708;
    check("pre_restart_cnt", {23'b0, load_count}, 32'd2);
    load_start = 1'b1; load_end = 1'b1; tick();
    load_start = 1'b0; load_end = 1'b0;
    check("restart_busy", {31'b0, load_busy}, 32'd1);
    check("restart_cnt", {23'b0, load_count}, 32'd0);
    stream = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    foreach (stream[i]) begin
      load_valid = 1'b1; load_byte = stream[i]; tick();
    end
    load_valid = 1'b0;
    load_end = 1'b1; tick(); load_end = 1'b0;
    ref_mem[0] = 32'hAABB_CCDD;
    check("restart_final_cnt", {23'b0, load_count}, 32'd1);
    fetch_chk("restart_w0", 32'd0);
    fetch_chk("restart_w1", 32'd4);

    // Reset in the middle of a word: committed word survives, loader aborts.
    stream = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
    load_start = 1'b1; tick(); load_start = 1'b0;
    foreach (stream[i]) begin
      load_valid = 1'b1; load_byte = stream[i]; tick();
    end
    load_valid = 1'b0;
    rst_n = 1'b0; tick();
    check("midrst_busy", {31'b0, load_busy}, 32'd0);
    check("midrst_count", {23'b0, load_count}, 32'd0);
    rst_n = 1'b1;
    ref_mem[0] = 32'h1234_5678;
    fetch_chk("midrst_w0", 32'd0);
    fetch_chk("midrst_w1", 32'd4);

    // Four-word memory: overflow on the 17th byte.
    s_start = 1'b1; tick(); s_start = 1'b0;
    for (int i = 0; i < 17; i++) begin
      s_valid = 1'b1; s_byte = 8'(i); tick();
      if (i == 15) begin
        check("small_ready_full", {31'b0, s_ready}, 32'd0);
        check("small_ovf_pre", {31'b0, s_ovf}, 32'd0);
      end
    end
    s_valid = 1'b0;
    check("small_ovf", {31'b0, s_ovf}, 32'd1);
    check("small_count", {29'b0, s_count}, 32'd4);
    s_end = 1'b1; tick(); s_end = 1'b0;
    check("small_ovf_sticky", {31'b0, s_ovf}, 32'd1);
    s_pc = 32'd16; tick();
    check("small_oor", s_instr, NOP);
    s_pc = 32'd4; tick();
    check("small_w1", s_instr, 32'h0405_0607);
    s_pc = 32'd12; tick();
    check("small_w3", s_instr, 32'h0C0D_0E0F);
    s_start = 1'b1; tick(); s_start = 1'b0;
    check("small_ovf_clr", {31'b0, s_ovf}, 32'd0);
    s_end = 1'b1; tick(); s_end = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
